stream_downsize: RTL and testbench

- Parametrised wide-to-narrow stream converter; the counterpart of stream_upsize in the stream_resize design.
- Accepts one beat of T_DATA_RATIO words with a count-encoded keep and a last flag.
- Emits the kept words one per cycle on a narrow valid/ready stream, with full backpressure and zero-bubble back-to-back operation.
- Replaces the tied-off downsize path of the top-level wrapper.

---
 rtl/stream_downsize.sv | 103 ++++++++++
 tb/tb_stream_downsize.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: one beat of T_DATA_RATIO words in, the kept
// words out one per cycle with full backpressure and zero-bubble beat handoff.
module stream_downsize #(
  parameter int T_DATA_WIDTH  = 32,
  parameter int T_DATA_RATIO  = 3,
  parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [T_DATA_WIDTH-1:0]   s_data_i [T_DATA_RATIO],
  input  logic [T_WIDTH_RATIO:0]    s_keep_i,
  input  logic                      s_last_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  output logic [T_DATA_WIDTH-1:0]   m_data_o,
  output logic                      m_last_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic                      err_o
);

  localparam int KW = T_WIDTH_RATIO + 1;
  localparam int IW = T_WIDTH_RATIO;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  function automatic logic [KW-1:0] clamp_keep(input logic [KW-1:0] k);
    return (k > KW'(T_DATA_RATIO)) ? KW'(T_DATA_RATIO) : k;
  endfunction

  logic [0:0]              state;
  logic [T_DATA_WIDTH-1:0] buf_p0 [T_DATA_RATIO];
  logic [KW-1:0]           cnt_p0;
  logic [IW-1:0]           idx_p0;
  logic                    last_p0;
  logic [T_DATA_WIDTH-1:0] data_p0;
  logic                    err_p0;

  logic          vld_p0;
  logic          at_last;
  logic          accept;
  logic          keep_zero;
  logic          keep_over;
  logic [KW-1:0] keep_eff;
  logic [IW-1:0] idx_nxt;

  assign vld_p0    = (state == SEND);
  assign at_last   = ({1'b0, idx_p0} == (cnt_p0 - KW'(1)));
  assign idx_nxt   = idx_p0 + IW'(1);
  assign s_ready_o = (state == IDLE) || (vld_p0 && m_ready_i && at_last);
  assign accept    = s_valid_i && s_ready_o;
  assign keep_zero = (s_keep_i == '0);
  assign keep_over = (s_keep_i > KW'(T_DATA_RATIO));
  assign keep_eff  = clamp_keep(s_keep_i);

  // Capture stage: words are held without reset; the control state decides validity.
  always_ff @(posedge clk) begin
    if (accept && !keep_zero) begin
      buf_p0 <= s_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt_p0  <= '0;
      idx_p0  <= '0;
      last_p0 <= 1'b0;
      data_p0 <= '0;
      err_p0  <= 1'b0;
    end else if (accept) begin
      // A zero-keep beat is dropped, even when it arrives on a final-word handoff.
      if (keep_zero) begin
        state  <= IDLE;
        err_p0 <= 1'b1;
      end else begin
        state   <= SEND;
        cnt_p0  <= keep_eff;
        idx_p0  <= '0;
        last_p0 <= s_last_i;
        data_p0 <= s_data_i[0];
        if (keep_over) begin
          err_p0 <= 1'b1;
        end
      end
    end else if (vld_p0 && m_ready_i) begin
      if (at_last) begin
        state <= IDLE;
      end else begin
        idx_p0  <= idx_nxt;
        data_p0 <= buf_p0[idx_nxt];
      end
    end
  end

  // Output stage: everything driven from registers, no path from s_* to m_*.
  assign m_valid_o = vld_p0;
  assign m_data_o  = data_p0;
  assign m_last_o  = vld_p0 && last_p0 && at_last;
  assign err_o     = err_p0;

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize (RATIO=3, W=32): per-cycle vector table
// plus a hand-written reset-mid-packet sequence.
module tb_stream_downsize;

  localparam int W = 32;
  localparam int R = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_data [R];
  logic [2:0]    s_keep;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [2:0] keep;
    logic       last;
    logic [7:0] base;
    logic       mr;
    logic       e_mv;
    logic [31:0] e_d;
    logic       e_ml;
    logic       e_sr;
    logic       e_err;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic vld, input logic [2:0] keep, input logic last,
                              input logic [7:0] base, input logic mr, input logic e_mv,
                              input logic [31:0] e_d, input logic e_ml, input logic e_sr,
                              input logic e_err);
    vec_t v;
    v.vld = vld; v.keep = keep; v.last = last; v.base = base; v.mr = mr;
    v.e_mv = e_mv; v.e_d = e_d; v.e_ml = e_ml; v.e_sr = e_sr; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Lane i of beat "base" carries base*16+i, so every word is distinguishable.
  task automatic drive(input logic vld, input logic [2:0] keep, input logic last,
                       input logic [7:0] base, input logic mr);
    s_valid = vld;
    s_keep  = keep;
    s_last  = last;
    m_ready = mr;
    for (int i = 0; i < R; i++) s_data[i] = 32'(base) * 32'd16 + 32'(i);
  endtask

  task automatic check_out(input string tag, input logic e_mv, input logic [31:0] e_d,
                           input logic e_ml, input logic e_sr, input logic e_err);
    check({tag, ".m_valid"}, 32'(m_valid), 32'(e_mv));
    check({tag, ".m_data"},  m_data, e_d);
    check({tag, ".m_last"},  32'(m_last), 32'(e_ml));
    check({tag, ".s_ready"}, 32'(s_ready), 32'(e_sr));
    check({tag, ".err"},     32'(err), 32'(e_err));
  endtask

  initial begin
    //            vld keep last base mr | mv  data    ml sr err
    tbl[0]  = mk(1, 3, 1, 1, 1,  0, 32'h00, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1,  1, 32'h10, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1,  1, 32'h11, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1,  1, 32'h12, 1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1,  0, 32'h12, 0, 1, 0);
    tbl[5]  = mk(1, 3, 0, 2, 1,  0, 32'h12, 0, 1, 0);
    tbl[6]  = mk(1, 2, 1, 3, 1,  1, 32'h20, 0, 0, 0);
    tbl[7]  = mk(1, 2, 1, 3, 1,  1, 32'h21, 0, 0, 0);
    tbl[8]  = mk(1, 2, 1, 3, 1,  1, 32'h22, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1,  1, 32'h30, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 1,  1, 32'h31, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 1,  0, 32'h31, 0, 1, 0);
    tbl[12] = mk(1, 3, 0, 4, 1,  0, 32'h31, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 1,  1, 32'h40, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,  1, 32'h41, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0,  1, 32'h41, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 1,  1, 32'h41, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 1,  1, 32'h42, 0, 1, 0);
    tbl[18] = mk(1, 1, 1, 5, 1,  0, 32'h42, 0, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 1,  1, 32'h50, 1, 1, 0);
    tbl[20] = mk(1, 2, 0, 6, 1,  0, 32'h50, 0, 1, 0);
    tbl[21] = mk(0, 0, 0, 0, 1,  1, 32'h60, 0, 0, 0);
    tbl[22] = mk(1, 0, 1, 7, 0,  1, 32'h61, 0, 0, 0);
    tbl[23] = mk(1, 0, 1, 7, 1,  1, 32'h61, 0, 1, 0);
    tbl[24] = mk(0, 0, 0, 0, 1,  0, 32'h61, 0, 1, 1);
    tbl[25] = mk(1, 5, 1, 8, 1,  0, 32'h61, 0, 1, 1);
    tbl[26] = mk(0, 0, 0, 0, 1,  1, 32'h80, 0, 0, 1);
    tbl[27] = mk(0, 0, 0, 0, 1,  1, 32'h81, 0, 0, 1);
    tbl[28] = mk(0, 0, 0, 0, 1,  1, 32'h82, 1, 1, 1);
    tbl[29] = mk(1, 0, 1, 9, 1,  0, 32'h82, 0, 1, 1);
    tbl[30] = mk(0, 0, 0, 0, 1,  0, 32'h82, 0, 1, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.m_valid", 32'(m_valid), 32'd0);
    check("rst.m_last",  32'(m_last),  32'd0);
    check("rst.m_data",  m_data,       32'd0);
    check("rst.err",     32'(err),     32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      @(posedge clk);
      #1 drive(tbl[r].vld, tbl[r].keep, tbl[r].last, tbl[r].base, tbl[r].mr);
      #1 check_out($sformatf("row%0d", r), tbl[r].e_mv, tbl[r].e_d, tbl[r].e_ml,
                   tbl[r].e_sr, tbl[r].e_err);
    end

    // Reset asserted while the second word of a keep=3 beat is on the output.
    @(posedge clk);
    #1 drive(1, 3, 1, 10, 1);
    #1 check("mid.accept.s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 1);
    #1 check("mid.w0.m_data", m_data, 32'hA0);
    @(posedge clk);
    #1 check("mid.w1.m_data", m_data, 32'hA1);
    rst_n = 1'b0;
    #1;
    check("mid.rst.m_valid", 32'(m_valid), 32'd0);
    check("mid.rst.m_last",  32'(m_last),  32'd0);
    check("mid.rst.m_data",  m_data,       32'd0);
    check("mid.rst.err",     32'(err),     32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2 check_out("post.idle", 0, 32'h0, 0, 1, 0);
    @(posedge clk);
    #1 drive(1, 2, 1, 11, 1);
    #1 check_out("post.accept", 0, 32'h0, 0, 1, 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 1);
    #1 check_out("post.w0", 1, 32'hB0, 0, 0, 0);
    @(posedge clk);
    #2 check_out("post.w1", 1, 32'hB1, 1, 1, 0);
    @(posedge clk);
    #2 check_out("post.done", 0, 32'hB1, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
